// File: rtl/scan_index_gen.sv
// scan_index_gen: timed index sequencer for a one-hot decoder stage.
// The index sweeps a latched window [lo..hi] in up, down, ping-pong or
// one-shot order. Each index value is held for div+1 clock cycles.
module scan_index_gen #(
    parameter int IDX_W = 4,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] div,
    input  logic [IDX_W-1:0] first,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] idx,
    output logic             idx_valid,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_UP      = 2'd0;
    localparam logic [1:0] MODE_DOWN    = 2'd1;
    localparam logic [1:0] MODE_PING    = 2'd2;
    localparam logic [1:0] MODE_ONESHOT = 2'd3;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    state_t           state_reg;
    logic [1:0]       mode_reg;
    logic [DIV_W-1:0] div_reg;
    logic [DIV_W-1:0] cnt_reg;
    logic [IDX_W-1:0] lo_reg;
    logic [IDX_W-1:0] hi_reg;
    logic [IDX_W-1:0] idx_reg;
    logic             dir_reg;
    logic             valid_reg;
    logic             busy_reg;
    logic             done_reg;

    // Window bounds ordered at latch time so lo <= hi always holds in RUN.
    logic             swap_in;
    logic [IDX_W-1:0] lo_in;
    logic [IDX_W-1:0] hi_in;

    assign swap_in = (first > last);

    generate
        for (genvar gi = 0; gi < IDX_W; gi++) begin : g_window
            assign lo_in[gi] = swap_in ? last[gi]  : first[gi];
            assign hi_in[gi] = swap_in ? first[gi] : last[gi];
        end
    endgenerate

    // Start index: DOWN sweeps begin at the top of the window.
    logic [IDX_W-1:0] start_idx;
    assign start_idx = (mode == MODE_DOWN) ? hi_in : lo_in;

    // Dwell boundary: this is the cycle on which a step is taken.
    logic dwell_end;
    assign dwell_end = (cnt_reg == div_reg);

    // Next index / direction for one step, with explicit wrap at the window
    // edges so the index never leaves [lo..hi].
    logic [IDX_W-1:0] step_idx_next;
    logic             step_dir_next;
    logic             step_finish;

    always_comb begin
        step_idx_next = idx_reg;
        step_dir_next = dir_reg;
        step_finish   = 1'b0;
        case (mode_reg)
            MODE_UP: begin
                if (idx_reg >= hi_reg) begin
                    step_idx_next = lo_reg;
                end else begin
                    step_idx_next = idx_reg + IDX_W'(1);
                end
            end
            MODE_DOWN: begin
                if (idx_reg <= lo_reg) begin
                    step_idx_next = hi_reg;
                end else begin
                    step_idx_next = idx_reg - IDX_W'(1);
                end
            end
            MODE_PING: begin
                if (dir_reg == DIR_UP) begin
                    if (idx_reg >= hi_reg) begin
                        // Turn around without repeating the endpoint.
                        step_dir_next = DIR_DOWN;
                        if (idx_reg > lo_reg) begin
                            step_idx_next = idx_reg - IDX_W'(1);
                        end
                    end else begin
                        step_idx_next = idx_reg + IDX_W'(1);
                    end
                end else begin
                    if (idx_reg <= lo_reg) begin
                        step_dir_next = DIR_UP;
                        if (idx_reg < hi_reg) begin
                            step_idx_next = idx_reg + IDX_W'(1);
                        end
                    end else begin
                        step_idx_next = idx_reg - IDX_W'(1);
                    end
                end
            end
            default: begin
                // One-shot: climb to hi, then finish after hi's dwell.
                if (idx_reg < hi_reg) begin
                    step_idx_next = idx_reg + IDX_W'(1);
                end else begin
                    step_finish = 1'b1;
                end
            end
        endcase
    end

    // Control FSM with registered outputs; stop in RUN overrides any step.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            mode_reg  <= MODE_UP;
            div_reg   <= '0;
            cnt_reg   <= '0;
            lo_reg    <= '0;
            hi_reg    <= '0;
            idx_reg   <= '0;
            dir_reg   <= DIR_UP;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    done_reg <= 1'b0;
                    if (start && !stop) begin
                        state_reg <= S_RUN;
                        mode_reg  <= mode;
                        div_reg   <= div;
                        lo_reg    <= lo_in;
                        hi_reg    <= hi_in;
                        idx_reg   <= start_idx;
                        dir_reg   <= DIR_UP;
                        cnt_reg   <= '0;
                        valid_reg <= 1'b1;
                        busy_reg  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        state_reg <= S_IDLE;
                        cnt_reg   <= '0;
                        valid_reg <= 1'b0;
                        busy_reg  <= 1'b0;
                    end else if (dwell_end) begin
                        cnt_reg <= '0;
                        if (step_finish) begin
                            state_reg <= S_DONE;
                            valid_reg <= 1'b0;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end else begin
                            idx_reg <= step_idx_next;
                            dir_reg <= step_dir_next;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + DIV_W'(1);
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                    done_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= S_IDLE;
                    valid_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign idx       = idx_reg;
    assign idx_valid = valid_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;

endmodule
